// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared MIPS core definitions: nPC_sel encodings, ifu states, default reset PC
package cpu_pkg;

    // Next-PC select encodings driven by the controller
    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_BNE  = 3'b010;
    localparam logic [2:0] NPC_J    = 3'b011;
    localparam logic [2:0] NPC_JAL  = 3'b100;
    localparam logic [2:0] NPC_JR   = 3'b101;
    localparam logic [2:0] NPC_STOP = 3'b110;

    // Instruction fetch unit sequencing states
    typedef enum logic [1:0] {
        IFU_IDLE  = 2'd0,
        IFU_FETCH = 2'd1,
        IFU_EXEC  = 2'd2,
        IFU_HALT  = 2'd3
    } ifu_state_t;

    // Program counter value loaded on reset unless overridden
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_npc.sv
// rtl/ifu_npc.sv - combinational next-PC selection for the fetch unit
module npc
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [2:0]      nPC_sel,
    input  logic            zero,
    input  logic [15:0]     imm16,
    input  logic [25:0]     target26,
    input  logic [31:0]     ra,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] sext_imm;
    logic [PC_W-1:0] branch_pc;
    logic [PC_W-1:0] jump_pc;

    // All arithmetic wraps modulo 2^PC_W; branch offsets are in words
    assign seq_pc    = pc + PC_W'(1);
    assign sext_imm  = {{(PC_W-16){imm16[15]}}, imm16};
    assign branch_pc = seq_pc + sext_imm;
    assign jump_pc   = {seq_pc[PC_W-1:26], target26};

    // Select the successor PC; reserved encoding falls back to sequential
    always_comb begin
        next_pc = seq_pc;
        case (nPC_sel)
            NPC_SEQ:  next_pc = seq_pc;
            NPC_BEQ:  next_pc = zero ? branch_pc : seq_pc;
            NPC_BNE:  next_pc = zero ? seq_pc : branch_pc;
            NPC_J:    next_pc = jump_pc;
            NPC_JAL:  next_pc = jump_pc;
            NPC_JR:   next_pc = ra[PC_W-1:0];
            NPC_STOP: next_pc = pc;
            default:  next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, fetch handshake, instruction register (optional IFU_INSTR_CNT_EN retired counter)
module ifu
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      nPC_sel,
    input  logic            zero,
    input  logic [15:0]     imm16,
    input  logic [25:0]     target26,
    input  logic [31:0]     ra,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            halted,
    output logic [31:0]     retired_cnt
);

    ifu_state_t      state;
    logic [PC_W-1:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus1  = pc + PC_W'(1);

    npc #(
        .PC_W(PC_W)
    ) u_npc (
        .pc       (pc),
        .nPC_sel  (nPC_sel),
        .zero     (zero),
        .imm16    (imm16),
        .target26 (target26),
        .ra       (ra),
        .next_pc  (next_pc)
    );

    // Fetch/execute sequencer; outputs are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IFU_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    // One dead cycle drops any response issued before reset
                    state    <= IFU_FETCH;
                    imem_req <= 1'b1;
                end
                IFU_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        state       <= IFU_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                IFU_EXEC: begin
                    pc          <= next_pc;
                    instr_valid <= 1'b0;
                    if (nPC_sel == NPC_STOP) begin
                        state  <= IFU_HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= IFU_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                IFU_HALT: begin
                    state <= IFU_HALT;
                end
                default: begin
                    state    <= IFU_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_INSTR_CNT_EN
    logic [31:0] retired_q;

    // Count every EXEC exit, the stop instruction included
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else if (state == IFU_EXEC) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - scoreboard testbench for the instruction fetch unit
module tb_ifu;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  nPC_sel;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        halted;
    logic [31:0] retired_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    ifu #(
        .PC_W     (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nPC_sel     (nPC_sel),
        .zero        (zero),
        .imm16       (imm16),
        .target26    (target26),
        .ra          (ra),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) v = exp_q.pop_front();
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
    endfunction

    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [2:0] s,
                                              input logic z, input logic [15:0] i,
                                              input logic [25:0] t, input logic [31:0] r);
        logic [31:0] p1;
        logic [31:0] off;
        p1  = p + 32'd1;
        off = {{16{i[15]}}, i};
        case (s)
            3'b001:  return z ? p1 + off : p1;
            3'b010:  return z ? p1 : p1 + off;
            3'b011:  return {p1[31:26], t};
            3'b100:  return {p1[31:26], t};
            3'b101:  return r;
            3'b110:  return p;
            default: return p1;
        endcase
    endfunction

    task automatic check_retired(input string tag);
`ifdef IFU_INSTR_CNT_EN
        expect_eq(tag, retired_cnt, m_ret);
`else
        expect_eq(tag, retired_cnt, 32'd0);
`endif
    endtask

    // Entered at a negedge with the DUT in its first FETCH cycle
    task automatic run_instr(input logic [2:0] sel, input logic z, input logic [15:0] imm,
                             input logic [25:0] tgt, input logic [31:0] rav,
                             input int waits, input logic spurious);
        logic [31:0] nxt;
        expect_eq("fetch_req", {31'd0, imem_req}, 32'd1);
        expect_eq("fetch_addr", imem_addr, m_pc);
        for (int w = 0; w < waits; w++) begin
            imem_valid = 1'b0;
            @(negedge clk);
            expect_eq("wait_req", {31'd0, imem_req}, 32'd1);
            expect_eq("wait_ivalid", {31'd0, instr_valid}, 32'd0);
            expect_eq("wait_pc", pc, m_pc);
        end
        imem_valid = 1'b1;
        imem_rdata = mem_word(m_pc);
        exp_q.push_back(mem_word(m_pc));
        exp_q.push_back(m_pc);
        @(negedge clk);
        imem_valid = spurious;
        imem_rdata = ~mem_word(m_pc);
        expect_eq("exec_ivalid", {31'd0, instr_valid}, 32'd1);
        expect_eq("exec_req", {31'd0, imem_req}, 32'd0);
        expect_eq("exec_instr", instr, pop_exp());
        expect_eq("exec_pc", pc, pop_exp());
        expect_eq("exec_pc_plus1", pc_plus1, m_pc + 32'd1);
        nPC_sel  = sel;
        zero     = z;
        imm16    = imm;
        target26 = tgt;
        ra       = rav;
        nxt = model_npc(m_pc, sel, z, imm, tgt, rav);
        exp_q.push_back(nxt);
        @(negedge clk);
        imem_valid = 1'b0;
        if (spurious) expect_eq("spurious_instr", instr, mem_word(m_pc));
        expect_eq("next_pc", pc, pop_exp());
        m_pc = nxt;
        m_ret = m_ret + 32'd1;
        expect_eq("post_ivalid", {31'd0, instr_valid}, 32'd0);
        if (sel == 3'b110) begin
            expect_eq("stop_halted", {31'd0, halted}, 32'd1);
            expect_eq("stop_req", {31'd0, imem_req}, 32'd0);
        end else begin
            expect_eq("post_halted", {31'd0, halted}, 32'd0);
            expect_eq("post_req", {31'd0, imem_req}, 32'd1);
        end
        check_retired("retired");
        nPC_sel = 3'b000;
    endtask

    task automatic check_reset_state(input string tag);
        expect_eq({tag, "_pc"}, pc, 32'h0);
        expect_eq({tag, "_instr"}, instr, 32'h0);
        expect_eq({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
        expect_eq({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        expect_eq({tag, "_halted"}, {31'd0, halted}, 32'd0);
        expect_eq({tag, "_retired"}, retired_cnt, 32'd0);
    endtask

    // Release reset at a negedge with a stale response that the IDLE cycle must drop
    task automatic release_with_stale();
        reset      = 1'b0;
        expect_eq("idle_req", {31'd0, imem_req}, 32'd0);
        imem_valid = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_valid = 1'b0;
        expect_eq("first_req", {31'd0, imem_req}, 32'd1);
        expect_eq("stale_ivalid", {31'd0, instr_valid}, 32'd0);
        expect_eq("stale_instr", instr, 32'h0);
        expect_eq("restart_addr", imem_addr, 32'h0);
        m_pc  = 32'h0;
        m_ret = 32'h0;
    endtask

    initial begin
        reset      = 1'b1;
        nPC_sel    = 3'b000;
        zero       = 1'b0;
        imm16      = 16'h0;
        target26   = 26'h0;
        ra         = 32'h0;
        imem_rdata = 32'h0;
        imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        release_with_stale();

        run_instr(3'b000, 1'b0, 16'h0,    26'h0,     32'h0,         0, 1'b0);
        run_instr(3'b000, 1'b0, 16'h0,    26'h0,     32'h0,         3, 1'b1);
        run_instr(3'b000, 1'b0, 16'h0,    26'h0,     32'h0,         0, 1'b0);
        expect_eq("three_fetched_pc", pc, 32'd3);
        run_instr(3'b101, 1'b0, 16'h0,    26'h0,     32'd5,         1, 1'b0);
        run_instr(3'b001, 1'b1, 16'hFFFE, 26'h0,     32'h0,         0, 1'b1);
        expect_eq("beq_taken_pc", pc, 32'd4);
        run_instr(3'b101, 1'b0, 16'h0,    26'h0,     32'd5,         0, 1'b0);
        run_instr(3'b001, 1'b0, 16'hFFFE, 26'h0,     32'h0,         2, 1'b0);
        expect_eq("beq_not_taken_pc", pc, 32'd6);
        run_instr(3'b010, 1'b0, 16'h0010, 26'h0,     32'h0,         0, 1'b0);
        run_instr(3'b010, 1'b1, 16'h0010, 26'h0,     32'h0,         0, 1'b0);
        run_instr(3'b111, 1'b0, 16'h0,    26'h0,     32'h0,         0, 1'b0);
        run_instr(3'b101, 1'b0, 16'h0,    26'h0,     32'h0400_0010, 0, 1'b0);
        run_instr(3'b011, 1'b0, 16'h0,    26'h100,   32'h0,         0, 1'b0);
        expect_eq("j_pc", pc, 32'h0400_0100);
        run_instr(3'b101, 1'b0, 16'h0,    26'h0,     32'h0400_0010, 0, 1'b0);
        run_instr(3'b100, 1'b0, 16'h0,    26'h100,   32'h0,         0, 1'b0);
        run_instr(3'b101, 1'b0, 16'h0,    26'h0,     32'h0000_0040, 0, 1'b0);
        expect_eq("jr_pc", pc, 32'h40);
        run_instr(3'b110, 1'b0, 16'h0,    26'h0,     32'h0,         0, 1'b0);

        for (int c = 0; c < 20; c++) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            nPC_sel    = 3'($urandom_range(0, 7));
            @(negedge clk);
            expect_eq("halt_req", {31'd0, imem_req}, 32'd0);
            expect_eq("halt_pc", pc, 32'h40);
            expect_eq("halt_halted", {31'd0, halted}, 32'd1);
            expect_eq("halt_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        imem_valid = 1'b0;
        nPC_sel    = 3'b000;

        reset = 1'b1;
        @(negedge clk);
        check_reset_state("halt_rst");
        release_with_stale();

        run_instr(3'b101, 1'b0, 16'h0, 26'h0, 32'd7, 0, 1'b0);
        @(negedge clk);
        expect_eq("midfetch_pc", pc, 32'd7);
        #2 reset = 1'b1;
        #1;
        expect_eq("async_rst_pc", pc, 32'h0);
        expect_eq("async_rst_req", {31'd0, imem_req}, 32'd0);
        expect_eq("async_rst_retired", retired_cnt, 32'h0);
        @(negedge clk);
        release_with_stale();
        run_instr(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1, 1'b0);
        expect_eq("restart_pc", pc, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
